// File: rtl/axi_burst_rd_slave_if.sv
// AR/R channel bundle for axi_burst_rd_slave; the bench or refill master
// drives the master modport.
interface axi_burst_rd_slave_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_burst_rd_slave.sv
// AXI4-style read-burst responder over an internal word memory with a side write port.
// Define AXI_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP returns SLVERR.
module axi_burst_rd_slave #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_burst_rd_slave_if.slave  bus,
  input  logic                 mem_we,
  input  logic [31:0]          mem_waddr,
  input  logic [31:0]          mem_wdata
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN     = 33'(MEM_WORDS) << 2;
  localparam int unsigned LAT_INIT = (RESP_LATENCY > 1) ? RESP_LATENCY - 2 : 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  beats_q, beats_d;
  logic [1:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic [31:0] lat_q, lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  logic [31:0] mem [MEM_WORDS];

  logic        ld;
  logic [31:0] ld_addr;
  logic [7:0]  ld_rem;
  logic [1:0]  ld_burst;
  logic        ld_err;
  logic [31:0] nxt_addr;
  logic [AW-1:0] rd_idx;
  logic        req_err;
  logic        wrap_len_ok;

`ifdef AXI_WRAP_BURST_EN
  logic [5:0]  mask_q, mask_d;
  logic [5:0]  ld_mask;
  logic [5:0]  req_mask;
`endif

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  assign bus.arready = (state_q == S_IDLE);
  assign bus.rvalid  = (state_q == S_BURST);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

`ifdef AXI_WRAP_BURST_EN
  assign wrap_len_ok = (bus.arlen == 8'd1) || (bus.arlen == 8'd3) ||
                       (bus.arlen == 8'd7) || (bus.arlen == 8'd15);
  // Wrap window is (arlen+1)*4 bytes, so its offset mask is arlen*4+3.
  assign req_mask    = {bus.arlen[3:0], 2'b11};
`else
  assign wrap_len_ok = 1'b0;
`endif

  assign req_err = (bus.arsize != 3'b010) || (bus.arburst == 2'b11) ||
                   ((bus.arburst == 2'b10) && !wrap_len_ok);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    burst_d  = burst_q;
    err_d    = err_q;
    lat_d    = lat_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ld       = 1'b0;
    ld_addr  = addr_q;
    ld_rem   = beats_q;
    ld_burst = burst_q;
    ld_err   = err_q;
`ifdef AXI_WRAP_BURST_EN
    mask_d   = mask_q;
    ld_mask  = mask_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.arvalid) begin
          addr_d  = bus.araddr;
          beats_d = bus.arlen;
          burst_d = bus.arburst;
          err_d   = req_err;
`ifdef AXI_WRAP_BURST_EN
          mask_d  = req_mask;
`endif
          if (RESP_LATENCY > 1) begin
            state_d = S_WAIT;
            lat_d   = LAT_INIT;
          end else begin
            // Beat 0 is loaded straight from the request fields at the AR edge.
            ld       = 1'b1;
            ld_addr  = bus.araddr;
            ld_rem   = bus.arlen;
            ld_burst = bus.arburst;
            ld_err   = req_err;
`ifdef AXI_WRAP_BURST_EN
            ld_mask  = req_mask;
`endif
            state_d  = S_BURST;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 32'd0) begin
          ld      = 1'b1;
          state_d = S_BURST;
        end else begin
          lat_d = lat_q - 32'd1;
        end
      end
      S_BURST: begin
        if (bus.rready) begin
          if (rlast_q) begin
            state_d = S_IDLE;
            rdata_d = '0;
            rresp_d = RESP_OKAY;
            rlast_d = 1'b0;
          end else begin
            ld = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (ld_burst)
      2'b01:   nxt_addr = ld_addr + 32'd4;
`ifdef AXI_WRAP_BURST_EN
      2'b10:   nxt_addr = {ld_addr[31:6],
                           (ld_addr[5:0] & ~ld_mask) | ((ld_addr[5:0] + 6'd4) & ld_mask)};
`endif
      default: nxt_addr = ld_addr;
    endcase

    rd_idx = AW'((ld_addr - BASE_ADDR) >> 2);

    if (ld) begin
      rlast_d = (ld_rem == 8'd0);
      addr_d  = nxt_addr;
      beats_d = ld_rem - 8'd1;
      if (ld_err) begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else if (!in_range(ld_addr)) begin
        rresp_d = RESP_DECERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
`ifdef AXI_WRAP_BURST_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
`ifdef AXI_WRAP_BURST_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Memory contents survive reset; the held beat lives in rdata_q, so a
  // side write never disturbs a beat already presented.
  always_ff @(posedge clock) begin
    if (mem_we && in_range(mem_waddr)) begin
      mem[AW'((mem_waddr - BASE_ADDR) >> 2)] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// Self-checking bench for axi_burst_rd_slave: burst-level reference model plus
// directed bursts with literal expectations.
module tb_axi_burst_rd_slave;
  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned LAT       = 1;
`ifdef AXI_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;

  always #5 clock = ~clock;

  axi_burst_rd_slave_if bus ();

  axi_burst_rd_slave #(
    .MEM_WORDS   (MEM_WORDS),
    .BASE_ADDR   (BASE),
    .RESP_LATENCY(LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  int unsigned checks = 0;
  int unsigned passes = 0;

  beat_t       exp_q[$];
  logic [31:0] model_mem [MEM_WORDS];
  bit          front_valid = 1'b0;
  logic [31:0] front_data;
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          rst_seen = 1'b1;
  bit          pend_we = 1'b0;
  logic [31:0] pend_addr, pend_data;

  logic [31:0] log_data[$];
  logic [1:0]  log_resp[$];
  logic        log_last[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 4 * MEM_WORDS);
  endfunction

  // Expected beat list straight from the burst rules: address arithmetic per type.
  function automatic void gen_beats(input logic [31:0] a, input int len,
                                    input logic [2:0] size, input logic [1:0] burst);
    bit err;
    int unsigned win, base;
    beat_t b;
    err = (size != 3'd2) || (burst == 2'd3) ||
          (burst == 2'd2 && !(WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15)));
    win  = (len + 1) * 4;
    base = a - (a % win);
    for (int i = 0; i <= len; i++) begin
      case (burst)
        2'd0:    b.addr = a;
        2'd1:    b.addr = a + 4 * i;
        default: b.addr = base + ((a - base + 4 * i) % win);
      endcase
      b.resp = err ? 2'b10 : (addr_ok(b.addr) ? 2'b00 : 2'b11);
      b.last = (i == len);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clock) begin
    bit exp_ready, exp_valid;
    cyc++;
    if (rst_seen) begin
      chk("rst_rlast", {31'd0, bus.rlast}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_rresp", {30'd0, bus.rresp}, 32'd0);
    end
    exp_ready = (exp_q.size() == 0);
    exp_valid = (exp_q.size() != 0) && (cyc >= hs_cyc + int'(LAT) - 1);
    chk("arready", {31'd0, bus.arready}, {31'd0, exp_ready});
    chk("rvalid", {31'd0, bus.rvalid}, {31'd0, exp_valid});
    if (exp_valid) begin
      if (!front_valid) begin
        front_data  = (exp_q[0].resp == 2'b00) ? model_mem[(exp_q[0].addr - BASE) >> 2] : 32'd0;
        front_valid = 1'b1;
      end
      chk("rdata", bus.rdata, front_data);
      chk("rresp", {30'd0, bus.rresp}, {30'd0, exp_q[0].resp});
      chk("rlast", {31'd0, bus.rlast}, {31'd0, exp_q[0].last});
      if (bus.rready && !reset) begin
        log_data.push_back(bus.rdata);
        log_resp.push_back(bus.rresp);
        log_last.push_back(bus.rlast);
        void'(exp_q.pop_front());
        front_valid = 1'b0;
      end
    end
    if (pend_we && addr_ok(pend_addr)) model_mem[(pend_addr - BASE) >> 2] = pend_data;
    pend_we   = mem_we;
    pend_addr = mem_waddr;
    pend_data = mem_wdata;
    if (reset) begin
      exp_q.delete();
      front_valid = 1'b0;
      rst_seen    = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (bus.arvalid && exp_ready) begin
        gen_beats(bus.araddr, int'(bus.arlen), bus.arsize, bus.arburst);
        hs_cyc = cyc + 1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    step();
    mem_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    log_data.delete(); log_resp.delete(); log_last.delete();
    bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.arready) begin ok = 1'b1; break; end
    end
    chk("ar_handshake_timeout", {31'd0, ok}, 32'd1);
    step();
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #2;
      if (exp_q.size() == 0 && bus.arready) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  function automatic logic [31:0] ld(input int i);
    return (i < log_data.size()) ? log_data[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] lr(input int i);
    return (i < log_resp.size()) ? {30'd0, log_resp[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [31:0] wrap_exp [4];
    bit pat [7];
    bit ok;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.rready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) write_word(BASE + 32'h100 + 4 * i, 32'hA0 + i);
    write_word(BASE + 4 * MEM_WORDS - 4, 32'hDEAD_BEEF);
    write_word(BASE + 4 * MEM_WORDS + 32'h100, 32'h0000_0BAD);
    write_word(BASE - 4, 32'h0000_0BAD);

    // Plain INCR burst, one beat per cycle
    issue(BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    wait_idle();
    chk("incr_count", log_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("incr_data", ld(i), 32'hA0 + i);
    chk("incr_last0", {31'd0, log_last.size() > 0 && log_last[0]}, 32'd0);
    chk("incr_last3", {31'd0, log_last.size() > 3 && log_last[3]}, 32'd1);

    // Back-pressure pattern
    pat = '{1, 0, 0, 1, 1, 0, 1};
    bus.rready = 1'b0;
    issue(BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 7; i++) begin bus.rready = pat[i]; step(); end
    bus.rready = 1'b1;
    wait_idle();
    chk("bp_count", log_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_data", ld(i), 32'hA0 + i);

    // WRAP burst
    issue(BASE + 32'h108, 8'd3, 3'd2, 2'b10);
    wait_idle();
    wrap_exp = WRAP_EN ? '{32'hA2, 32'hA3, 32'hA0, 32'hA1} : '{0, 0, 0, 0};
    chk("wrap_count", log_data.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_data", ld(i), wrap_exp[i]);
      chk("wrap_resp", lr(i), WRAP_EN ? 32'd0 : 32'd2);
    end

    // Unsupported size
    issue(BASE + 32'h100, 8'd1, 3'd0, 2'b01);
    wait_idle();
    chk("size_count", log_data.size(), 32'd2);
    chk("size_resp0", lr(0), 32'd2);
    chk("size_data1", ld(1), 32'd0);
    chk("size_last1", {31'd0, log_last.size() > 1 && log_last[1]}, 32'd1);

    // Crossing the top of memory
    issue(BASE + 4 * MEM_WORDS - 4, 8'd1, 3'd2, 2'b01);
    wait_idle();
    chk("edge_data0", ld(0), 32'hDEAD_BEEF);
    chk("edge_resp0", lr(0), 32'd0);
    chk("edge_resp1", lr(1), 32'd3);
    chk("edge_data1", ld(1), 32'd0);

    // FIXED burst; arvalid asserted mid-burst must be ignored
    bus.rready = 1'b0;
    issue(BASE + 32'h104, 8'd2, 3'd2, 2'b00);
    bus.araddr = BASE + 32'h10C; bus.arvalid = 1'b1;
    step(); step(); step();
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    wait_idle();
    chk("fixed_count", log_data.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("fixed_data", ld(i), 32'hA1);

    // Reset during beat 2
    issue(BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #2;
      if (log_data.size() >= 2) begin ok = 1'b1; break; end
    end
    chk("rst_wait_timeout", {31'd0, ok}, 32'd1);
    reset = 1'b1; bus.rready = 1'b0;
    @(posedge clock);
    #2;
    chk("rst_mid_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_mid_arready", {31'd0, bus.arready}, 32'd1);
    reset = 1'b0; bus.rready = 1'b1;
    step();
    issue(BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    wait_idle();
    chk("post_rst_data0", ld(0), 32'hA0);
    chk("post_rst_count", log_data.size(), 32'd4);

    // Side writes while beat 0 is held: held beat unchanged, later beat updated
    bus.rready = 1'b0;
    issue(BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    write_word(BASE + 32'h100, 32'h11);
    write_word(BASE + 32'h10C, 32'hC3);
    bus.rready = 1'b1;
    wait_idle();
    chk("patch_data0", ld(0), 32'hA0);
    chk("patch_data2", ld(2), 32'hA2);
    chk("patch_data3", ld(3), 32'hC3);

    step(); step();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
